// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//
// Shared definitions for the bitstream serializer:
//   - state_t       : shifter state (IDLE = shifter empty, SHIFT = word in flight)
//   - DEFAULT_WIDTH : default number of bits per parallel word
//   - head_bit()    : selects which end of the shift register is on the wire
// ---------------------------------------------------------------------------
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The bit currently presented on the serial output. With MSB-first order
  // the word drains from the top, otherwise from the bottom.
  function automatic logic head_bit(input logic msb_first,
                                    input logic msb,
                                    input logic lsb);
    return msb_first ? msb : lsb;
  endfunction

endpackage

// File: rtl/bitstream_serializer.sv
// ---------------------------------------------------------------------------
// bitstream_serializer
//
// Accepts parallel words over a valid/ready handshake and shifts them out one
// bit per clock. A single holding register sits in front of the shifter so
// that the next word can be waiting when the current one finishes, giving a
// gapless stream at one bit per clock.
//
// Parameters:
//   WIDTH     : bits per input word (>= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : in_data is presented
//   in_ready  : a word can be accepted this cycle (holding register empty)
//   in_data   : parallel word to serialize
//   x         : serial bit, 0 whenever x_valid is 0
//   x_valid   : x carries a data bit this cycle
//   word_done : one-cycle pulse with the last bit of each word
//   busy      : shifter active or holding register occupied
// ---------------------------------------------------------------------------
module bitstream_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_valid_reg, hold_valid_next;

  logic             accept;
  logic [WIDTH-1:0] shifted;

  // in_ready depends only on registered state, so there is no combinational
  // path from in_valid back to in_ready.
  assign in_ready = !hold_valid_reg;
  assign accept   = in_valid && !hold_valid_reg;

  // Shift register advanced by one position toward the head end; the vacated
  // end fills with zero so no stale data ever reaches the output.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
    end
  end

  // Next-state logic. Accepting a word and draining the holding register are
  // mutually exclusive: accepting needs hold empty, draining needs it full.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;

    if (accept) begin
      hold_next       = in_data;
      hold_valid_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (hold_valid_reg) begin
          shift_next      = hold_reg;
          cnt_next        = '0;
          hold_valid_next = 1'b0;
          state_next      = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_reg != LAST) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + CW'(1);
        end else if (hold_valid_reg) begin
          // Last bit on the wire now; reload so the next word's first bit
          // follows on the very next cycle.
          shift_next      = hold_reg;
          cnt_next        = '0;
          hold_valid_next = 1'b0;
        end else begin
          shift_next = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        shift_next = '0;
      end
    endcase
  end

  // Outputs are decoded purely from registered state.
  assign x_valid   = (state_reg == SHIFT);
  assign x         = x_valid && head_bit(MSB_FIRST, shift_reg[WIDTH-1], shift_reg[0]);
  assign word_done = (state_reg == SHIFT) && (cnt_reg == LAST);
  assign busy      = (state_reg == SHIFT) || hold_valid_reg;

endmodule

// File: tb/tb_bitstream_serializer.sv
// ---------------------------------------------------------------------------
// tb_bitstream_serializer
//
// Two serializers (MSB-first and LSB-first) share one stimulus stream. A
// schedule-based model predicts, per cycle, which bit of which accepted word
// is on the wire and when the holding register is occupied; a compare process
// checks every output of both instances on each falling edge.
// ---------------------------------------------------------------------------
module tb_bitstream_serializer;

  localparam int W = 8;
  localparam int N = 4096;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic rdy_m, x_m, xv_m, done_m, busy_m;
  logic rdy_l, x_l, xv_l, done_l, busy_l;

  int errors = 0;
  int checks = 0;

  bitstream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
    .x(x_m), .x_valid(xv_m), .word_done(done_m), .busy(busy_m)
  );

  bitstream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
    .x(x_l), .x_valid(xv_l), .word_done(done_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Model: per-cycle expectation tables. Cycle c is the cycle that starts
  // at rising edge number c.
  // ------------------------------------------------------------------
  int cyc = 0;
  int next_free = 0;
  bit e_valid [N];
  bit e_xm    [N];
  bit e_xl    [N];
  bit e_done  [N];
  bit e_hold  [N];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int i = cyc - 1; i < N; i++) begin
          e_valid[i] = 0; e_xm[i] = 0; e_xl[i] = 0; e_done[i] = 0; e_hold[i] = 0;
        end
        next_free = 0;
      end else if (in_valid && !e_hold[cyc-1]) begin
        // Word accepted at edge cyc; it enters the shifter at edge ld, which
        // is the next edge or when the previous word has fully left.
        int ld;
        ld = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        for (int i = cyc; i < ld && i < N; i++) e_hold[i] = 1;
        for (int k = 0; k < W; k++) begin
          if (ld + k < N) begin
            e_valid[ld+k] = 1;
            e_xm[ld+k]    = in_data[W-1-k];
            e_xl[ld+k]    = in_data[k];
            e_done[ld+k]  = (k == W - 1);
          end
        end
        next_free = ld + W;
      end
    end
  end

  // Compare process: every cycle, both instances.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_xv_m", xv_m, 0);   chk("rst_xv_l", xv_l, 0);
        chk("rst_x_m", x_m, 0);     chk("rst_x_l", x_l, 0);
        chk("rst_done_m", done_m, 0); chk("rst_done_l", done_l, 0);
        chk("rst_busy_m", busy_m, 0); chk("rst_busy_l", busy_l, 0);
        chk("rst_rdy_m", rdy_m, 1);   chk("rst_rdy_l", rdy_l, 1);
      end else begin
        chk("xv_m", xv_m, e_valid[cyc]);   chk("xv_l", xv_l, e_valid[cyc]);
        chk("x_m", x_m, e_xm[cyc]);        chk("x_l", x_l, e_xl[cyc]);
        chk("done_m", done_m, e_done[cyc]); chk("done_l", done_l, e_done[cyc]);
        chk("busy_m", busy_m, e_valid[cyc] | e_hold[cyc]);
        chk("busy_l", busy_l, e_valid[cyc] | e_hold[cyc]);
        chk("rdy_m", rdy_m, !e_hold[cyc]); chk("rdy_l", rdy_l, !e_hold[cyc]);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers. All of them start and end just after a falling edge.
  // ------------------------------------------------------------------
  task automatic send(input logic [W-1:0] w, input bit keep, output int acc_c);
    int  b;
    bit  r;
    in_valid = 1'b1;
    in_data  = w;
    acc_c    = -1;
    b        = 0;
    forever begin
      r = rdy_m;
      @(posedge clk);
      #1;
      if (r) begin
        acc_c = cyc;
        $display("send: word %02h accepted in cycle %0d", w, acc_c);
        break;
      end
      b++;
      if (b > 100) begin
        chk("send_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic capture(input int nbits, output logic [31:0] bm, output logic [31:0] bl,
                         output logic [31:0] vm, output logic [31:0] dm, output int first_c);
    int b;
    bm = '0; bl = '0; vm = '0; dm = '0; first_c = -1;
    b = 0;
    @(negedge clk);
    while (!xv_m && b < 60) begin
      @(negedge clk);
      b++;
    end
    if (!xv_m) begin
      chk("capture_timeout", 0, 1);
    end else begin
      first_c = cyc;
      for (int k = 0; k < nbits; k++) begin
        bm = {bm[30:0], x_m};
        bl = {bl[30:0], x_l};
        vm = {vm[30:0], xv_m};
        dm = {dm[30:0], done_m};
        if (k < nbits - 1) @(negedge clk);
      end
    end
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_x_m"}, x_m, 0);   chk({tag, "_xv_m"}, xv_m, 0);
    chk({tag, "_x_l"}, x_l, 0);   chk({tag, "_xv_l"}, xv_l, 0);
    chk({tag, "_busy"}, busy_m, 0); chk({tag, "_rdy"}, rdy_m, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic [31:0] bm, bl, vm, dm;
  int          acc0, acc1, acc2, fc;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk_reset_now("reset");
    chk("reset_done", done_m, 0);
    #1 rst = 1'b0;
    idle(2);

    // Single word, both bit orders.
    fork
      send(8'hD6, 1'b0, acc0);
      capture(8, bm, bl, vm, dm, fc);
    join
    $display("single D6: msb=%02h lsb=%02h done=%02h first=%0d acc=%0d", bm[7:0], bl[7:0], dm[7:0], fc, acc0);
    chk("d6_msb_bits", bm[7:0], 8'hD6);
    chk("d6_lsb_bits", bl[7:0], 8'h6B);
    chk("d6_valid", vm[7:0], 8'hFF);
    chk("d6_done", dm[7:0], 8'h01);
    chk("d6_latency", fc - acc0, 1);
    @(negedge clk);
    chk("d6_after_xv", xv_m, 0);
    chk("d6_after_x", x_m, 0);
    #1;
    idle(3);

    // Back-to-back with in_valid held high.
    fork
      begin
        send(8'hFF, 1'b1, acc0);
        send(8'h00, 1'b0, acc1);
      end
      capture(16, bm, bl, vm, dm, fc);
    join
    $display("b2b FF,00: msb=%04h lsb=%04h valid=%04h done=%04h", bm[15:0], bl[15:0], vm[15:0], dm[15:0]);
    chk("b2b_msb", bm[15:0], 16'hFF00);
    chk("b2b_lsb", bl[15:0], 16'hFF00);
    chk("b2b_valid", vm[15:0], 16'hFFFF);
    chk("b2b_done", dm[15:0], 16'h0101);
    idle(4);

    // Backpressure: the third word waits while the hold register is full.
    fork
      begin
        send(8'h3C, 1'b1, acc0);
        send(8'hA5, 1'b1, acc1);
        send(8'h0F, 1'b0, acc2);
      end
      capture(24, bm, bl, vm, dm, fc);
    join
    $display("backpressure 3C,A5,0F: msb=%06h lsb=%06h acc=%0d,%0d,%0d", bm[23:0], bl[23:0], acc0, acc1, acc2);
    chk("bp_msb", bm[23:0], 24'h3CA50F);
    chk("bp_lsb", bl[23:0], 24'h3CA5F0);
    chk("bp_valid", vm[23:0], 24'hFFFFFF);
    chk("bp_done", dm[23:0], 24'h010101);
    chk("bp_wait", acc2 - acc1, 8);
    idle(4);

    // Reset after the third bit of AA.
    fork
      send(8'hAA, 1'b0, acc0);
      begin
        int b;
        b = 0;
        @(negedge clk);
        while (!xv_m && b < 60) begin
          @(negedge clk);
          b++;
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_now("midword_rst");
        $display("reset asserted mid-word in cycle %0d", cyc);
      end
    join
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(2);
    fork
      send(8'h35, 1'b0, acc0);
      capture(8, bm, bl, vm, dm, fc);
    join
    $display("post-reset 35: msb=%02h lsb=%02h", bm[7:0], bl[7:0]);
    chk("post_rst_msb", bm[7:0], 8'h35);
    chk("post_rst_lsb", bl[7:0], 8'hAC);
    chk("post_rst_latency", fc - acc0, 1);
    idle(3);

    // Randomized traffic with occasional asynchronous resets.
    begin
      bit r;
      bit xfer;
      int pv;
      xfer = 1;
      pv   = 3;
      for (int i = 0; i < 1500; i++) begin
        if (i % 100 == 0) pv = $urandom_range(1, 4);
        if ($urandom_range(0, 199) == 0) begin
          in_valid = 1'b0;
          rst      = 1'b1;
          #1 chk_reset_now("rand_rst");
          $display("random reset in cycle %0d", cyc);
          @(posedge clk);
          @(negedge clk);
          #1 rst = 1'b0;
          xfer = 1;
        end else begin
          if (xfer || !in_valid) begin
            in_valid = ($urandom_range(1, 4) <= pv);
            in_data  = W'($urandom);
          end
          r    = rdy_m;
          xfer = in_valid && r;
          if (xfer) $display("rand: word %02h offered with in_ready=1 in cycle %0d", in_data, cyc);
          @(negedge clk);
          #1;
        end
      end
    end
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
